// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a simple valid/ready command into one APB transfer, then returns the
// result on a valid/ready response port. Only one transfer is in flight at a
// time. The command is taken only while the bridge is idle. Every command
// then walks through SETUP, ACCESS (which may stretch on wait states) and RESP.
//
// Parameters
//   ADDR_W   APB address width
//   DATA_W   data width (STRB_W = DATA_W/8 byte lanes)
//   TIMEOUT  maximum ACCESS cycles to wait for PREADY; 0 waits forever
//
// Ports
//   PCLK, PRESET              clock and synchronous active-high reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_write, cmd_addr,      command contents, latched on acceptance
//   cmd_wdata, cmd_strb
//   rsp_valid / rsp_ready     response handshake
//   rsp_rdata, rsp_err,       response contents, held stable while
//   rsp_timeout               rsp_valid is waiting for rsp_ready
//   PSEL, PENABLE, PWRITE,    APB master request outputs (all registered)
//   PADDR, PWDATA, PSTRB
//   PREADY, PSLVERR, PRDATA   APB completer replies, looked at only in ACCESS
// ---------------------------------------------------------------------------
module apb_master_bridge #(
   parameter  int ADDR_W  = 32,
   parameter  int DATA_W  = 32,
   parameter  int TIMEOUT = 16,
   localparam int STRB_W  = DATA_W / 8
) (
   input  logic              PCLK,
   input  logic              PRESET,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_strb,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,

   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic [STRB_W-1:0] PSTRB,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic [DATA_W-1:0] PRDATA
);

   // The wait counter never needs to count past TIMEOUT-1, because the
   // transfer is aborted at that point. With the timeout disabled the counter
   // may wrap freely, since nothing compares against it then.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_WAIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } BridgeState;

   BridgeState       state;
   BridgeState       nextState;
   logic [CNT_W-1:0] waitCount;
   logic             cmdAccept;
   logic             accessDone;
   logic             timeoutHit;

   // State register. Reset takes priority over everything, so a transfer
   // caught mid-flight is simply dropped and no response is ever produced
   // for it.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode. PREADY is checked before the timeout. That way a
   // completer that answers on the very last allowed cycle still completes
   // normally instead of being reported as timed out. The APB reply inputs are
   // only examined in ACCESS, so noise on them elsewhere has no effect.
   always_comb begin
      nextState  = state;
      cmdAccept  = 1'b0;
      accessDone = 1'b0;
      timeoutHit = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               cmdAccept = 1'b1;
               nextState = SETUP;
            end
         end
         SETUP: begin
            nextState = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               accessDone = 1'b1;
               nextState  = RESP;
            end else if ((TIMEOUT > 0) && (waitCount == LAST_WAIT)) begin
               timeoutHit = 1'b1;
               nextState  = RESP;
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Wait-state counter. It is cleared while in SETUP, so it reads zero on the
   // first ACCESS cycle. It then advances once for every ACCESS cycle the
   // completer stalls.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         waitCount <= '0;
      end else if (state == SETUP) begin
         waitCount <= '0;
      end else if ((state == ACCESS) && !PREADY) begin
         waitCount <= waitCount + CNT_W'(1);
      end
   end

   // Registered outputs. The handshake and phase outputs are decoded from the
   // upcoming state, so they line up exactly with the state they describe and
   // stay glitch-free. The APB request fields are loaded once at acceptance
   // and left alone afterwards. This keeps them stable through SETUP and
   // ACCESS and also lets them hold their last values while idle. Read
   // requests drive zero data and strobes. The response fields change only
   // when ACCESS finishes, so they stay frozen while RESP waits for the
   // consumer.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         cmd_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         PSEL      <= (nextState == SETUP) || (nextState == ACCESS);
         PENABLE   <= (nextState == ACCESS);
         cmd_ready <= (nextState == IDLE);
         rsp_valid <= (nextState == RESP);

         if (cmdAccept) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_write ? cmd_wdata : '0;
            PSTRB  <= cmd_write ? cmd_strb  : '0;
         end

         if (accessDone) begin
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
         end else if (timeoutHit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. Each transaction is described by
// its command, the number of wait states the completer inserts, the
// completer's reply and how long the consumer stalls the response. From
// those numbers the bench works out, for every cycle after acceptance,
// which APB phase the bridge must be in and what it must present. The
// completer and consumer are driven from that same timeline, so any drift in
// the bridge's timing shows up as a phase mismatch.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;
   localparam int TIMEOUT = 16;

   logic              PCLK = 1'b0;
   logic              PRESET;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_strb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [STRB_W-1:0] PSTRB;
   logic              PREADY;
   logic              PSLVERR;
   logic [DATA_W-1:0] PRDATA;

   int checks = 0;
   int errors = 0;
   int txnId  = 0;

   apb_master_bridge #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_strb   (cmd_strb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PSTRB      (PSTRB),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR),
      .PRDATA     (PRDATA)
   );

   // Free-running 100 MHz clock.
   always #5 PCLK = ~PCLK;

   // Compares one observed value with the expected value and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL txn %0d %s: observed 0x%0h, expected 0x%0h",
                  txnId, tag, observed, expected);
      end
   endtask

   // Advances one clock. Sampling and driving both happen 1 ns after the edge.
   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // Puts random values on the completer reply inputs, which must be ignored
   // outside ACCESS.
   task automatic scrambleReply();
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
   endtask

   // Runs a number of idle cycles with no command presented.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_valid = 1'b0;
         scrambleReply();
         step();
         checkOutput("idle cmd_ready", 64'(cmd_ready), 64'd1);
         checkOutput("idle PSEL",      64'(PSEL),      64'd0);
         checkOutput("idle rsp_valid", 64'(rsp_valid), 64'd0);
      end
   endtask

   // Issues one command and follows it cycle by cycle until the bridge is
   // idle again. Cycle k counts clock edges after the accepting edge: k=1 is
   // SETUP, and ACCESS lasts effWaits+1 cycles. RESP lasts rspDelay+1 cycles,
   // and the cycle after that is idle. A completer that stalls TIMEOUT or more
   // cycles gets its transfer cut off after the TIMEOUT-th ACCESS cycle.
   task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata,
                                input logic [STRB_W-1:0] strb, input int waits,
                                input logic slverr,
                                input logic [DATA_W-1:0] rdata,
                                input int rspDelay);
      logic              isTimeout;
      int                effWaits;
      int                respStart;
      int                idleAt;
      logic              expErr;
      logic [DATA_W-1:0] expRdata;
      logic [DATA_W-1:0] expWdata;
      logic [STRB_W-1:0] expStrb;
      logic              inSetup, inAccess, inResp, inIdle;

      txnId++;
      isTimeout = (TIMEOUT > 0) && (waits >= TIMEOUT);
      effWaits  = isTimeout ? TIMEOUT - 1 : waits;
      respStart = 3 + effWaits;
      idleAt    = respStart + rspDelay + 1;
      expErr    = isTimeout ? 1'b1 : slverr;
      expRdata  = (isTimeout || wr) ? '0 : rdata;
      expWdata  = wr ? wdata : '0;
      expStrb   = wr ? strb  : '0;

      checkOutput("accept cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      rsp_ready = 1'($urandom);
      scrambleReply();

      for (int k = 1; k <= idleAt; k++) begin
         step();
         if (k == 1) begin
            cmd_valid = 1'b0;
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_strb  = STRB_W'($urandom);
         end
         inSetup  = (k == 1);
         inAccess = (k >= 2) && (k <= 2 + effWaits);
         inResp   = (k >= respStart) && (k < idleAt);
         inIdle   = (k == idleAt);

         checkOutput("PSEL",      64'(PSEL),      64'(inSetup || inAccess));
         checkOutput("PENABLE",   64'(PENABLE),   64'(inAccess));
         checkOutput("rsp_valid", 64'(rsp_valid), 64'(inResp));
         checkOutput("cmd_ready", 64'(cmd_ready), 64'(inIdle));
         checkOutput("PADDR",     64'(PADDR),     64'(addr));
         checkOutput("PWRITE",    64'(PWRITE),    64'(wr));
         checkOutput("PWDATA",    64'(PWDATA),    64'(expWdata));
         checkOutput("PSTRB",     64'(PSTRB),     64'(expStrb));
         if (inResp) begin
            checkOutput("rsp_rdata",   64'(rsp_rdata),   64'(expRdata));
            checkOutput("rsp_err",     64'(rsp_err),     64'(expErr));
            checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(isTimeout));
         end

         if (inAccess) begin
            if (!isTimeout && (k - 1 == waits + 1)) begin
               PREADY  = 1'b1;
               PSLVERR = slverr;
               PRDATA  = rdata;
            end else begin
               PREADY  = 1'b0;
               PSLVERR = 1'($urandom);
               PRDATA  = $urandom;
            end
         end else begin
            scrambleReply();
         end

         if (inResp) begin
            rsp_ready = ((k - respStart) >= rspDelay);
         end else begin
            rsp_ready = 1'($urandom);
         end
      end
   endtask

   // Starts a write, stalls it in ACCESS, then pulses reset. All outputs must
   // clear, and the bridge must be ready again on the first cycle after reset
   // is released, without ever raising a response.
   task automatic resetDuringAccess(input int accessCycles);
      txnId++;
      checkOutput("rst accept cmd_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h0000_0044;
      cmd_wdata = 32'hA5A5_A5A5;
      cmd_strb  = 4'hF;
      rsp_ready = 1'b1;
      PREADY    = 1'b0;
      step();
      cmd_valid = 1'b0;
      checkOutput("rst SETUP PSEL", 64'(PSEL), 64'd1);
      for (int i = 0; i < accessCycles; i++) begin
         step();
         checkOutput("rst ACCESS PENABLE", 64'(PENABLE), 64'd1);
      end
      PRESET = 1'b1;
      step();
      checkOutput("rst PSEL",        64'(PSEL),        64'd0);
      checkOutput("rst PENABLE",     64'(PENABLE),     64'd0);
      checkOutput("rst PWRITE",      64'(PWRITE),      64'd0);
      checkOutput("rst PADDR",       64'(PADDR),       64'd0);
      checkOutput("rst PWDATA",      64'(PWDATA),      64'd0);
      checkOutput("rst PSTRB",       64'(PSTRB),       64'd0);
      checkOutput("rst cmd_ready",   64'(cmd_ready),   64'd0);
      checkOutput("rst rsp_valid",   64'(rsp_valid),   64'd0);
      checkOutput("rst rsp_rdata",   64'(rsp_rdata),   64'd0);
      checkOutput("rst rsp_err",     64'(rsp_err),     64'd0);
      checkOutput("rst rsp_timeout", 64'(rsp_timeout), 64'd0);
      PRESET = 1'b0;
      step();
      checkOutput("post-rst cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("post-rst rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post-rst PSEL",      64'(PSEL),      64'd0);
   endtask

   // Main sequence: reset, directed scenarios, then a random mix.
   initial begin
      logic              wr;
      logic              slv;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] rdata;
      logic [STRB_W-1:0] strb;
      int                waits;

      PRESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      rsp_ready = 1'b0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      repeat (3) step();
      checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("reset PSEL",      64'(PSEL),      64'd0);
      checkOutput("reset PENABLE",   64'(PENABLE),   64'd0);
      checkOutput("reset rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset PADDR",     64'(PADDR),     64'd0);
      checkOutput("reset rsp_err",   64'(rsp_err),   64'd0);
      PRESET = 1'b0;
      step();
      checkOutput("reset release cmd_ready", 64'(cmd_ready), 64'd1);

      // Zero-wait write.
      applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 0);
      // Read with three wait states.
      applyStimulus(1'b0, 32'h20, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
      // Write completed with a slave error.
      applyStimulus(1'b1, 32'h24, 32'h0BAD_F00D, 4'h3, 1, 1'b1, 32'h0, 0);
      // Stalled read that times out, then one that answers on the last cycle.
      applyStimulus(1'b0, 32'h28, 32'h0, 4'h0, TIMEOUT, 1'b0, 32'h5555_AAAA, 0);
      applyStimulus(1'b0, 32'h2C, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'hCAFE_0001, 0);
      // Response held back by the consumer for five cycles.
      applyStimulus(1'b0, 32'h34, 32'h0, 4'h0, 0, 1'b0, 32'h8765_4321, 5);
      idleCycles(2);
      // Reset in the middle of ACCESS, followed by a normal read.
      resetDuringAccess(3);
      applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 1, 1'b0, 32'h0F0F_1234, 0);

      for (int t = 0; t < 40; t++) begin
         wr    = 1'($urandom);
         addr  = $urandom;
         wdata = $urandom;
         strb  = STRB_W'($urandom);
         slv   = 1'($urandom);
         rdata = $urandom;
         waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 3))
                                             : int'($urandom_range(0, 4));
         applyStimulus(wr, addr, wdata, strb, waits, slv, rdata, int'($urandom_range(0, 3)));
         idleCycles(int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Backstop in case the sequence ever stops advancing.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no completion, expected $finish before 2 ms");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
